// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM device model.
//   - CMD_* : 4-bit {cs, ras, cas, we} command encodings
//   - ERR_* : protocol violation codes latched by the model (1..7)
//   - MODE_* : field positions inside the mode word
//   - bank_t : per-bank tracking state (open flag, open row, ACTIVE->RD/WR counter)
package sdram_pkg;

   localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_BST       = 4'b0110;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;
   localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_CLOSED     = 3'd1;
   localparam logic [2:0] ERR_RCD        = 3'd2;
   localparam logic [2:0] ERR_ACT_OPEN   = 3'd3;
   localparam logic [2:0] ERR_NOT_IDLE   = 3'd4;
   localparam logic [2:0] ERR_NO_MODE    = 3'd5;
   localparam logic [2:0] ERR_BAD_MODE   = 3'd6;
   localparam logic [2:0] ERR_CONTENTION = 3'd7;

   localparam int MODE_BL_LSB = 0;
   localparam int MODE_BL_MSB = 2;
   localparam int MODE_CL_LSB = 4;
   localparam int MODE_CL_MSB = 6;
   localparam int MODE_OP_LSB = 7;
   localparam int MODE_OP_MSB = 8;

   typedef struct packed {
      logic        open;
      logic [12:0] row;
      logic [3:0]  rcd_cnt;
   } bank_t;

   // Only single-beat bursts, CL 2 or 3 and standard operation are modelled.
   function automatic logic mode_word_legal(input logic [12:0] w);
      return (w[MODE_BL_MSB:MODE_BL_LSB] == 3'd0) &&
             ((w[MODE_CL_MSB:MODE_CL_LSB] == 3'd2) || (w[MODE_CL_MSB:MODE_CL_LSB] == 3'd3)) &&
             (w[MODE_OP_MSB:MODE_OP_LSB] == 2'd0);
   endfunction

   // DQM bit set means the byte is masked, so its output enables stay low.
   function automatic logic [15:0] dqm_to_oe(input logic [1:0] dqm);
      return {{8{~dqm[1]}}, {8{~dqm[0]}}};
   endfunction

endpackage

// File: rtl/sdram_model_mem.sv
// sdram_model_mem: single-port 2^AW x 16 backing RAM for the SDRAM model.
//   clk   : clock
//   we    : byte write enables, [1] upper byte, [0] lower byte
//   rd_en : capture mem[addr] into rdata on this edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (one-cycle latency); contents are never reset
module sdram_model_mem #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic [1:0]    we,
   input  logic          rd_en,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem_r [2**AW];

   // Byte-enabled write port and registered read port sharing one address.
   always_ff @(posedge clk) begin
      if (we[0]) begin
         mem_r[addr][7:0] <= wdata[7:0];
      end
      if (we[1]) begin
         mem_r[addr][15:8] <= wdata[15:8];
      end
      if (rd_en) begin
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/sdram_device_model.sv
// sdram_device_model: device-side responder for a 16-bit SDR SDRAM bus.
// Decodes commands, tracks per-bank open rows, stores data in an internal
// byte-enabled RAM, returns read data after the programmed CAS latency and
// latches the first protocol violation.
//   clk, reset              : clock, synchronous active-high reset
//   sd_cke                  : clock enable; low freezes every piece of state
//   sd_cs/ras/cas/we        : active-low command pins
//   sd_ba, sd_addr, sd_dqm  : bank, address / mode word, byte masks
//   sd_data_in              : write data from the controller
//   sd_data_out, sd_data_oe : read data and per-bit output enables
//   mode_reg, mode_valid    : last legal mode word and its valid flag
//   err, err_code           : sticky first-violation flag and code
//   refresh_cnt             : saturating AUTO_REFRESH count
module sdram_device_model
   import sdram_pkg::*;
#(
   parameter int MEM_AW = 14,
   parameter int T_RCD  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sd_cke,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   input  logic [1:0]  sd_ba,
   input  logic [12:0] sd_addr,
   input  logic [1:0]  sd_dqm,
   input  logic [15:0] sd_data_in,
   output logic [15:0] sd_data_out,
   output logic [15:0] sd_data_oe,
   output logic [12:0] mode_reg,
   output logic        mode_valid,
   output logic        err,
   output logic [2:0]  err_code,
   output logic [15:0] refresh_cnt
);

   localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);

   bank_t             bank_r [4];
   // Read pipeline: stage 1 follows the RAM's registered read, stage 2 adds
   // the extra cycle needed for CL=3.
   logic              v1_r;
   logic              v2_r;
   logic              c1_r;
   logic [1:0]        m1_r;
   logic [1:0]        m2_r;
   logic [15:0]       d2_r;

   logic [3:0]        cmd_s;
   logic [2:0]        code_s;
   logic              any_open_s;
   logic              pend_s;
   logic              mode_ok_s;
   logic              rd_go_s;
   logic              wr_go_s;
   bank_t             cur_s;
   logic [MEM_AW-1:0] mem_addr_s;
   logic [1:0]        mem_we_s;
   logic [15:0]       mem_q_s;

   // Command decode, violation priority and RAM port control.
   always_comb begin
      cmd_s      = sd_cs ? CMD_INHIBIT : {1'b0, sd_ras, sd_cas, sd_we};
      cur_s      = bank_r[sd_ba];
      any_open_s = bank_r[0].open | bank_r[1].open | bank_r[2].open | bank_r[3].open;
      pend_s     = v1_r | v2_r | (sd_data_oe != 16'h0000);
      mode_ok_s  = mode_word_legal(sd_addr);
      code_s     = ERR_NONE;
      case (cmd_s)
         CMD_ACTIVE: begin
            if (cur_s.open) begin
               code_s = ERR_ACT_OPEN;
            end else if (!mode_valid) begin
               code_s = ERR_NO_MODE;
            end else begin
               code_s = ERR_NONE;
            end
         end
         CMD_READ, CMD_WRITE: begin
            if (!cur_s.open) begin
               code_s = ERR_CLOSED;
            end else if (cur_s.rcd_cnt != 4'd0) begin
               code_s = ERR_RCD;
            end else if (!mode_valid) begin
               code_s = ERR_NO_MODE;
            end else if ((cmd_s == CMD_WRITE) && pend_s) begin
               code_s = ERR_CONTENTION;
            end else begin
               code_s = ERR_NONE;
            end
         end
         CMD_REFRESH: begin
            code_s = any_open_s ? ERR_NOT_IDLE : ERR_NONE;
         end
         CMD_LOAD_MODE: begin
            if (any_open_s) begin
               code_s = ERR_NOT_IDLE;
            end else if (!mode_ok_s) begin
               code_s = ERR_BAD_MODE;
            end else begin
               code_s = ERR_NONE;
            end
         end
         default: code_s = ERR_NONE;
      endcase
      // A closed bank has no row to address, so such accesses do nothing.
      rd_go_s    = sd_cke && (cmd_s == CMD_READ)  && cur_s.open;
      wr_go_s    = sd_cke && (cmd_s == CMD_WRITE) && cur_s.open;
      // Truncation of {ba, row, col} is deliberate: addresses alias.
      mem_addr_s = MEM_AW'({sd_ba, cur_s.row, sd_addr[8:0]});
      mem_we_s   = wr_go_s ? ~sd_dqm : 2'b00;
   end

   sdram_model_mem #(
      .AW(MEM_AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .rd_en (rd_go_s),
      .addr  (mem_addr_s),
      .wdata (sd_data_in),
      .rdata (mem_q_s)
   );

   // Bank tracking, mode/refresh/error registers and the read pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            bank_r[i] <= '0;
         end
         v1_r        <= 1'b0;
         v2_r        <= 1'b0;
         c1_r        <= 1'b0;
         m1_r        <= 2'b00;
         m2_r        <= 2'b00;
         d2_r        <= 16'h0000;
         sd_data_out <= 16'h0000;
         sd_data_oe  <= 16'h0000;
         mode_reg    <= 13'h0000;
         mode_valid  <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_NONE;
         refresh_cnt <= 16'h0000;
      end else if (sd_cke) begin
         for (int i = 0; i < 4; i++) begin
            if (bank_r[i].rcd_cnt != 4'd0) begin
               bank_r[i].rcd_cnt <= bank_r[i].rcd_cnt - 4'd1;
            end
         end
         case (cmd_s)
            CMD_ACTIVE: begin
               bank_r[sd_ba].open    <= 1'b1;
               bank_r[sd_ba].row     <= sd_addr;
               bank_r[sd_ba].rcd_cnt <= RCD_LOAD;
            end
            CMD_READ, CMD_WRITE: begin
               if (sd_addr[10]) begin
                  bank_r[sd_ba].open <= 1'b0;
               end
            end
            CMD_PRECHARGE: begin
               if (sd_addr[10]) begin
                  for (int i = 0; i < 4; i++) begin
                     bank_r[i].open <= 1'b0;
                  end
               end else begin
                  bank_r[sd_ba].open <= 1'b0;
               end
            end
            CMD_REFRESH: begin
               if (refresh_cnt != 16'hFFFF) begin
                  refresh_cnt <= refresh_cnt + 16'd1;
               end
            end
            CMD_LOAD_MODE: begin
               if (!any_open_s && mode_ok_s) begin
                  mode_reg   <= sd_addr;
                  mode_valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase

         if (!err && (code_s != ERR_NONE)) begin
            err      <= 1'b1;
            err_code <= code_s;
         end

         v1_r <= rd_go_s;
         m1_r <= sd_dqm;
         c1_r <= (mode_reg[MODE_CL_MSB:MODE_CL_LSB] == 3'd3);
         v2_r <= v1_r & c1_r;
         m2_r <= m1_r;
         d2_r <= mem_q_s;
         if (v1_r && !c1_r) begin
            sd_data_out <= mem_q_s;
            sd_data_oe  <= dqm_to_oe(m1_r);
         end else if (v2_r) begin
            sd_data_out <= d2_r;
            sd_data_oe  <= dqm_to_oe(m2_r);
         end else begin
            sd_data_oe  <= 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_sdram_device_model.sv
// Self-checking bench for sdram_device_model: a command-level reference model
// predicts every output per active clock edge; directed scenarios add literal
// expectations, then a randomized legal traffic phase runs against the model.
module tb_sdram_device_model;

   localparam int MEM_AW = 14;
   localparam int T_RCD  = 1;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   logic        clk;
   logic        reset = 1'b1;
   logic        sd_cke = 1'b1;
   logic        sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
   logic [1:0]  sd_ba = 2'd0;
   logic [12:0] sd_addr = 13'd0;
   logic [1:0]  sd_dqm = 2'd0;
   logic [15:0] sd_data_in = 16'd0;
   logic [15:0] sd_data_out, sd_data_oe, refresh_cnt;
   logic [12:0] mode_reg;
   logic        mode_valid, err;
   logic [2:0]  err_code;

   sdram_device_model #(.MEM_AW(MEM_AW), .T_RCD(T_RCD)) dut (
      .clk(clk), .reset(reset), .sd_cke(sd_cke),
      .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
      .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm),
      .sd_data_in(sd_data_in), .sd_data_out(sd_data_out), .sd_data_oe(sd_data_oe),
      .mode_reg(mode_reg), .mode_valid(mode_valid), .err(err),
      .err_code(err_code), .refresh_cnt(refresh_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;

   function automatic void check(string nm, logic [31:0] got, logic [31:0] want,
                                 logic [31:0] mask = 32'hFFFF_FFFF);
      n_chk++;
      if (((got ^ want) & mask) != 32'd0) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (mask %h) at %0t", nm, got, want, mask, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   bit          m_open [4];
   logic [12:0] m_row [4];
   int          m_act_edge [4];
   logic [12:0] m_mode;
   bit          m_mv, m_err;
   int          m_code, m_ref;
   int          act = 0;           // count of edges on which the device advanced
   int          last_rd_end;       // edge at which the latest read's enables drop
   logic [15:0] m_mem [int];
   logic [1:0]  m_known [int];
   logic [15:0] e_oe [int];
   logic [15:0] e_dat [int];
   logic [15:0] e_km [int];
   bit          started = 1'b0;

   task automatic model_step();
      logic [3:0]  c;
      logic [15:0] w;
      logic [1:0]  k;
      int          code, a, cl, b;
      bit          any_open;
      if (reset) begin
         act++;
         for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
         m_mode = 13'd0; m_mv = 1'b0; m_err = 1'b0; m_code = 0; m_ref = 0;
         last_rd_end = -1000;
         e_oe.delete(); e_dat.delete(); e_km.delete();
         return;
      end
      if (!sd_cke) return;
      act++;
      b = int'(sd_ba);
      any_open = m_open[0] || m_open[1] || m_open[2] || m_open[3];
      c = sd_cs ? 4'hF : {1'b0, sd_ras, sd_cas, sd_we};
      code = 0;
      a = int'({sd_ba, m_row[b], sd_addr[8:0]}) & ((1 << MEM_AW) - 1);
      case (c)
         C_ACT: begin
            if (m_open[b]) code = 3; else if (!m_mv) code = 5;
            m_open[b] = 1'b1; m_row[b] = sd_addr; m_act_edge[b] = act;
         end
         C_RD, C_WR: begin
            if (!m_open[b]) code = 1;
            else if (act - m_act_edge[b] < T_RCD) code = 2;
            else if (!m_mv) code = 5;
            else if (c == C_WR && act <= last_rd_end) code = 7;
            if (m_open[b]) begin
               if (!m_mem.exists(a)) begin m_mem[a] = 16'h0; m_known[a] = 2'b00; end
               w = m_mem[a]; k = m_known[a];
               if (c == C_WR) begin
                  if (!sd_dqm[0]) begin w[7:0]  = sd_data_in[7:0];  k[0] = 1'b1; end
                  if (!sd_dqm[1]) begin w[15:8] = sd_data_in[15:8]; k[1] = 1'b1; end
                  m_mem[a] = w; m_known[a] = k;
               end else begin
                  cl = int'(m_mode[6:4]);
                  e_oe[act + cl - 1]  = {{8{~sd_dqm[1]}}, {8{~sd_dqm[0]}}};
                  e_dat[act + cl - 1] = w;
                  e_km[act + cl - 1]  = {{8{k[1]}}, {8{k[0]}}};
                  last_rd_end = act + cl;
               end
               if (sd_addr[10]) m_open[b] = 1'b0;
            end
         end
         C_PRE: begin
            if (sd_addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
            else m_open[b] = 1'b0;
         end
         C_REF: begin
            if (any_open) code = 4;
            if (m_ref < 65535) m_ref++;
         end
         C_LMR: begin
            if (any_open) code = 4;
            else if (!(sd_addr[2:0] == 3'd0 && (sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3)
                       && sd_addr[8:7] == 2'd0)) code = 6;
            else begin m_mode = sd_addr; m_mv = 1'b1; end
         end
         default: begin end
      endcase
      if (!m_err && code != 0) begin m_err = 1'b1; m_code = code; end
   endtask

   // Compare process: every cycle, all outputs against the model.
   initial begin
      logic [15:0] eo;
      forever begin
         @(negedge clk);
         if (started) begin
            eo = e_oe.exists(act) ? e_oe[act] : 16'h0000;
            check("oe", 32'(sd_data_oe), 32'(eo));
            if (eo != 16'h0000) check("data", 32'(sd_data_out), 32'(e_dat[act]), 32'(e_km[act]));
            check("err", 32'(err), 32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("mode_valid", 32'(mode_valid), 32'(m_mv));
            check("mode_reg", 32'(mode_reg), 32'(m_mode));
            check("refresh_cnt", 32'(refresh_cnt), 32'(m_ref));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] ad,
                        input logic [1:0] dqm = 2'b00, input logic [15:0] d = 16'h0000);
      {sd_cs, sd_ras, sd_cas, sd_we} = c;
      sd_ba = ba; sd_addr = ad; sd_dqm = dqm; sd_data_in = d;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nop(1);
      reset = 1'b0;
      started = 1'b1;
   endtask

   task automatic init(input logic [12:0] mode);
      drive(C_PRE, 2'd0, 13'h400);
      drive(C_LMR, 2'd0, mode);
   endtask

   initial begin
      int r, b;
      logic [12:0] ad;
      do_reset();
      check("lit_reset_oe", 32'(sd_data_oe), 32'h0);
      check("lit_reset_ref", 32'(refresh_cnt), 32'h0);

      // Init then read
      drive(C_PRE, 2'd0, 13'h400);
      for (int i = 0; i < 8; i++) drive(C_REF, 2'd0, 13'd0);
      drive(C_LMR, 2'd0, 13'h220);
      check("lit_mode_valid", 32'(mode_valid), 32'd1);
      check("lit_refresh8", 32'(refresh_cnt), 32'd8);
      check("lit_model_ref8", 32'(m_ref), 32'd8);
      drive(C_ACT, 2'd0, 13'd5);
      drive(C_WR, 2'd0, 13'd3, 2'b00, 16'hA55A);
      drive(C_RD, 2'd0, 13'h403);
      check("lit_t1_oe_early", 32'(sd_data_oe), 32'h0);
      nop(1);
      check("lit_t1_oe", 32'(sd_data_oe), 32'hFFFF);
      check("lit_t1_data", 32'(sd_data_out), 32'hA55A);
      nop(1);
      check("lit_t1_oe_drop", 32'(sd_data_oe), 32'h0);
      drive(C_ACT, 2'd0, 13'd5);   // bank 0 must have auto-precharged
      check("lit_t1_err", 32'(err), 32'd0);

      // Byte masking
      drive(C_ACT, 2'd1, 13'd7);
      drive(C_WR, 2'd1, 13'd9, 2'b00, 16'hBEEF);
      drive(C_WR, 2'd1, 13'd9, 2'b10, 16'h1234);
      drive(C_RD, 2'd1, 13'd9, 2'b00);
      drive(C_RD, 2'd1, 13'd9, 2'b01);
      check("lit_t2_data", 32'(sd_data_out), 32'hBE34);
      check("lit_t2_oe", 32'(sd_data_oe), 32'hFFFF);
      nop(1);
      check("lit_t2_oe_mask", 32'(sd_data_oe), 32'hFF00);
      check("lit_t2_upper", 32'(sd_data_out[15:8]), 32'hBE);
      nop(1);
      drive(C_PRE, 2'd0, 13'h400);

      // CL=3 back-to-back, then CKE freeze
      drive(C_LMR, 2'd0, 13'h230);
      drive(C_ACT, 2'd2, 13'd3);
      drive(C_WR, 2'd2, 13'd1, 2'b00, 16'h1111);
      drive(C_WR, 2'd2, 13'd2, 2'b00, 16'h2222);
      drive(C_RD, 2'd2, 13'd1);
      drive(C_RD, 2'd2, 13'd2);
      check("lit_t3_oe_early", 32'(sd_data_oe), 32'h0);
      nop(1);
      check("lit_t3_d1", 32'(sd_data_out), 32'h1111);
      nop(1);
      check("lit_t3_d2", 32'(sd_data_out), 32'h2222);
      check("lit_t3_oe_cont", 32'(sd_data_oe), 32'hFFFF);
      nop(1);
      check("lit_t3_oe_drop", 32'(sd_data_oe), 32'h0);
      drive(C_RD, 2'd2, 13'd1);
      nop(2);
      sd_cke = 1'b0;
      nop(3);
      check("lit_cke_oe_hold", 32'(sd_data_oe), 32'hFFFF);
      check("lit_cke_data_hold", 32'(sd_data_out), 32'h1111);
      sd_cke = 1'b1;
      nop(1);
      check("lit_cke_oe_drop", 32'(sd_data_oe), 32'h0);
      drive(C_PRE, 2'd0, 13'h400);
      check("lit_legal_err", 32'(err), 32'd0);

      // Closed bank
      do_reset();
      init(13'h220);
      drive(C_ACT, 2'd0, 13'd1);
      drive(C_RD, 2'd1, 13'd0);
      check("lit_t4_err", 32'(err), 32'd1);
      check("lit_t4_code", 32'(err_code), 32'd1);
      drive(C_ACT, 2'd0, 13'd2);
      check("lit_t4_code_held", 32'(err_code), 32'd1);

      // Illegal mode, refresh with row open
      do_reset();
      drive(C_LMR, 2'd0, 13'h221);
      check("lit_t5_code6", 32'(err_code), 32'd6);
      check("lit_t5_mv", 32'(mode_valid), 32'd0);
      do_reset();
      init(13'h220);
      drive(C_ACT, 2'd0, 13'd2);
      drive(C_REF, 2'd0, 13'd0);
      check("lit_t5_code4", 32'(err_code), 32'd4);

      // Reset mid-read
      do_reset();
      init(13'h220);
      drive(C_REF, 2'd0, 13'd0);
      drive(C_ACT, 2'd0, 13'd5);
      drive(C_WR, 2'd0, 13'd3, 2'b00, 16'h5AA5);
      nop(1);
      drive(C_RD, 2'd0, 13'd3);
      do_reset();
      check("lit_t6_oe", 32'(sd_data_oe), 32'h0);
      check("lit_t6_ref", 32'(refresh_cnt), 32'h0);
      check("lit_t6_mv", 32'(mode_valid), 32'd0);
      check("lit_t6_mode", 32'(mode_reg), 32'h0);
      nop(2);
      check("lit_t6_oe_after", 32'(sd_data_oe), 32'h0);

      // Randomized legal traffic
      do_reset();
      drive(C_LMR, 2'd0, ($urandom_range(0, 1) == 0) ? 13'h220 : 13'h230);
      for (int s = 0; s < 1500; s++) begin
         r = $urandom_range(0, 9);
         b = $urandom_range(0, 3);
         sd_cke = ($urandom_range(0, 11) != 0);
         ad = 13'($urandom_range(0, 7));
         if (!sd_cke) begin
            nop(1);
         end else begin
            case (r)
               0, 1: begin
                  if (!m_open[b]) drive(C_ACT, 2'(b), 13'($urandom_range(0, 3)));
                  else drive(C_PRE, 2'(b), 13'd0);
               end
               2, 3, 4: begin
                  if (m_open[b] && act + 1 > last_rd_end) begin
                     if ($urandom_range(0, 7) == 0) ad[10] = 1'b1;
                     drive(C_WR, 2'(b), ad, 2'($urandom_range(0, 3)), 16'($urandom));
                  end else nop(1);
               end
               5, 6, 7: begin
                  if (m_open[b]) begin
                     if ($urandom_range(0, 5) == 0) ad[10] = 1'b1;
                     drive(C_RD, 2'(b), ad, 2'($urandom_range(0, 3)));
                  end else nop(1);
               end
               8: begin
                  if ($urandom_range(0, 2) == 0) drive(C_PRE, 2'd0, 13'h400);
                  else nop(1);
               end
               default: begin
                  if (!(m_open[0] || m_open[1] || m_open[2] || m_open[3])) drive(C_REF, 2'd0, 13'd0);
                  else nop(1);
               end
            endcase
         end
      end
      sd_cke = 1'b1;
      nop(5);
      check("lit_random_no_err", 32'(err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
